datapath_run_ctrl: RTL and testbench

//  Run/step controller that sequences the single-cycle datapath by driving its enable (lock) input.

---
 rtl/datapath_run_ctrl_pkg.sv | 30 +++
 rtl/datapath_run_ctrl.sv | 122 ++++++++++++
 tb/tb_datapath_run_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_run_ctrl_pkg.sv
// Shared encodings for the datapath run/step controller:
// run states, halt causes and host command opcodes.
package datapath_run_ctrl_pkg;

    typedef enum logic [1:0] {
        RUNST_IDLE   = 2'b00,
        RUNST_RUN    = 2'b01,
        RUNST_STEP   = 2'b10,
        RUNST_HALTED = 2'b11
    } run_state_e;

    typedef enum logic [1:0] {
        HALT_HOST = 2'b00,
        HALT_STEP = 2'b01,
        HALT_BP   = 2'b10,
        HALT_WDOG = 2'b11
    } halt_cause_e;

    typedef enum logic [1:0] {
        RCMD_NOP  = 2'b00,
        RCMD_RUN  = 2'b01,
        RCMD_STEP = 2'b10,
        RCMD_HALT = 2'b11
    } rcmd_e;

    function automatic logic is_active(input run_state_e s);
        return (s == RUNST_RUN) || (s == RUNST_STEP);
    endfunction

endpackage

// File: rtl/datapath_run_ctrl.sv
// Run/step controller driving datapath.lock, with PC breakpoint,
// step budget, run watchdog and retired-instruction counter.
module datapath_run_ctrl
    import datapath_run_ctrl_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              STEP_W   = 16,
    parameter int              WDOG_W   = 20,
    parameter logic [WDOG_W-1:0] WDOG_MAX = 20'hFFFFF,
    parameter int              CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] step_count,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   next_pc,
    output logic              lock,
    output logic [1:0]        state,
    output logic [1:0]        halt_cause,
    output logic              cmd_err,
    output logic [CNT_W-1:0]  retired_cnt
);

    run_state_e        r_state;
    halt_cause_e       r_cause;
    logic [STEP_W-1:0] r_step_rem;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_bp_skip;
    logic              r_cmd_err;
    logic [CNT_W-1:0]  r_retired;

    logic              w_bp_hit;
    logic              w_lock;
    logic              w_cmd_run;
    logic              w_cmd_step;
    logic              w_cmd_halt;
    logic              w_wdog_fire;
    logic              w_resume_skip;
    logic [STEP_W-1:0] w_step_load;

    assign w_bp_hit   = bp_en && (next_pc == bp_addr) && !r_bp_skip;
    assign w_lock     = !rst && is_active(r_state) && !w_bp_hit;
    assign w_cmd_run  = cmd_valid && (cmd_op == RCMD_RUN);
    assign w_cmd_step = cmd_valid && (cmd_op == RCMD_STEP);
    assign w_cmd_halt = cmd_valid && (cmd_op == RCMD_HALT);

    assign w_wdog_fire = (WDOG_MAX != '0) && (r_wdog == WDOG_MAX - 1'b1);

    // Resuming from a breakpoint halt must step over the matching PC once.
    assign w_resume_skip = (r_state == RUNST_HALTED) && (r_cause == HALT_BP);
    assign w_step_load   = (step_count == '0) ? STEP_W'(1) : step_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUNST_IDLE;
            r_cause    <= HALT_HOST;
            r_step_rem <= '0;
            r_wdog     <= '0;
            r_bp_skip  <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_cmd_err <= is_active(r_state) && (w_cmd_run || w_cmd_step);
            if (w_lock) begin
                r_retired <= r_retired + CNT_W'(1);
                r_bp_skip <= 1'b0;
            end
            unique case (r_state)
                RUNST_IDLE, RUNST_HALTED: begin
                    if (w_cmd_run) begin
                        r_state   <= RUNST_RUN;
                        r_wdog    <= '0;
                        r_bp_skip <= w_resume_skip;
                    end else if (w_cmd_step) begin
                        r_state    <= RUNST_STEP;
                        r_step_rem <= w_step_load;
                        r_bp_skip  <= w_resume_skip;
                    end
                end
                RUNST_RUN: begin
                    if (w_bp_hit) begin
                        r_state <= RUNST_HALTED;
                        r_cause <= HALT_BP;
                    end else if (w_wdog_fire) begin
                        r_state <= RUNST_HALTED;
                        r_cause <= HALT_WDOG;
                    end else if (w_cmd_halt) begin
                        r_state <= RUNST_HALTED;
                        r_cause <= HALT_HOST;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                RUNST_STEP: begin
                    if (w_bp_hit) begin
                        r_state <= RUNST_HALTED;
                        r_cause <= HALT_BP;
                    end else if (r_step_rem == STEP_W'(1)) begin
                        r_state <= RUNST_HALTED;
                        r_cause <= HALT_STEP;
                    end else if (w_cmd_halt) begin
                        r_state <= RUNST_HALTED;
                        r_cause <= HALT_HOST;
                    end else begin
                        r_step_rem <= r_step_rem - STEP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign lock        = w_lock;
    assign state       = r_state;
    assign halt_cause  = r_cause;
    assign cmd_err     = r_cmd_err;
    assign retired_cnt = r_retired;

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Randomized plus directed bench for datapath_run_ctrl against a
// cycle-level behavioural model of the run/step rules.
module tb_datapath_run_ctrl;

    localparam int WD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] step_count;
    logic        bp_en;
    logic [15:0] bp_addr;
    logic [15:0] next_pc;
    logic        lock;
    logic [1:0]  state;
    logic [1:0]  halt_cause;
    logic        cmd_err;
    logic [31:0] retired_cnt;

    datapath_run_ctrl #(
        .PC_W(16), .STEP_W(16), .WDOG_W(20),
        .WDOG_MAX(20'd8), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid),
        .cmd_op(cmd_op), .step_count(step_count),
        .bp_en(bp_en), .bp_addr(bp_addr), .next_pc(next_pc),
        .lock(lock), .state(state), .halt_cause(halt_cause),
        .cmd_err(cmd_err), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: mode 0 idle, 1 run, 2 step, 3 halted.
    int          m_mode, m_why, m_budget, m_runlen;
    bit          m_skip, m_err;
    logic [31:0] m_cnt;
    int          pc_mode;   // 0 sequential, 1 self-loop, 2 random jumps
    int          dut_ret;

    function automatic bit m_hit();
        return bp_en && (next_pc == bp_addr) && !m_skip;
    endfunction

    function automatic bit m_lock();
        return !rst && (m_mode == 1 || m_mode == 2) && !m_hit();
    endfunction

    task automatic model_edge();
        bit l, h, go_run, go_step, stop;
        l = m_lock();
        h = m_hit();
        if (rst) begin
            m_mode = 0; m_why = 0; m_budget = 0; m_runlen = 0;
            m_skip = 0; m_err = 0; m_cnt = 0;
            return;
        end
        go_run  = cmd_valid && cmd_op == 2'd1;
        go_step = cmd_valid && cmd_op == 2'd2;
        stop    = cmd_valid && cmd_op == 2'd3;
        m_err = (m_mode == 1 || m_mode == 2) && (go_run || go_step);
        if (l) begin
            m_cnt = m_cnt + 1;
            m_skip = 0;
        end
        if (m_mode == 0 || m_mode == 3) begin
            if (go_run || go_step) begin
                m_skip = (m_mode == 3 && m_why == 2);
                m_mode = go_run ? 1 : 2;
                m_runlen = 0;
                m_budget = (step_count == 0) ? 1 : int'(step_count);
            end
        end else if (h) begin
            m_mode = 3; m_why = 2;
        end else if (m_mode == 1) begin
            m_runlen++;
            if (m_runlen == WD) begin
                m_mode = 3; m_why = 3;
            end else if (stop) begin
                m_mode = 3; m_why = 0;
            end
        end else begin
            m_budget--;
            if (m_budget == 0) begin
                m_mode = 3; m_why = 1;
            end else if (stop) begin
                m_mode = 3; m_why = 0;
            end
        end
    endtask

    logic [15:0] pc;

    task automatic tick();
        bit l;
        #1;
        l = m_lock();
        if (lock) dut_ret++;
        check("lock", 32'(lock), 32'(l));
        check("state", 32'(state), 32'(m_mode));
        if (m_mode == 3) check("cause", 32'(halt_cause), 32'(m_why));
        check("cmd_err", 32'(cmd_err), 32'(m_err));
        check("retired", retired_cnt, m_cnt);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        if (l) begin
            if (pc_mode == 0) pc = pc + 16'd4;
            else if (pc_mode == 2) begin
                if ($urandom_range(0, 7) == 0)
                    pc = 16'($urandom_range(0, 15) * 4);
                else
                    pc = (pc + 16'd4) & 16'h003C;
            end
        end
        next_pc = pc;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic cmd(input logic [1:0] op, input logic [15:0] n);
        cmd_valid = 1'b1; cmd_op = op; step_count = n;
        tick();
        cmd_valid = 1'b0; cmd_op = 2'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pc = 16'd0; next_pc = 16'd0; dut_ret = 0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; step_count = 16'd0;
        bp_en = 1'b0; bp_addr = 16'd0; pc = 16'd0; next_pc = 16'd0;
        pc_mode = 0; dut_ret = 0;
        m_mode = 0; m_why = 0; m_budget = 0; m_runlen = 0;
        m_skip = 0; m_err = 0; m_cnt = 0;
        @(negedge clk);
        do_reset();
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_cause", 32'(halt_cause), 32'd0);
        check("rst_lock", 32'(lock), 32'd0);
        check("rst_cnt", retired_cnt, 32'd0);

        cmd(2'd2, 16'd3);
        idle(5);
        #1;
        check("t1_ret", 32'(dut_ret), 32'd3);
        check("t1_state", 32'(state), 32'd3);
        check("t1_cause", 32'(halt_cause), 32'd1);
        check("t1_cnt", retired_cnt, 32'd3);

        do_reset();
        cmd(2'd2, 16'd0);
        idle(3);
        #1;
        check("t6_ret0", 32'(dut_ret), 32'd1);
        cmd(2'd2, 16'd1);
        cmd(2'd3, 16'd0);
        #1;
        check("t6_cause", 32'(halt_cause), 32'd1);

        do_reset();
        bp_en = 1'b1; bp_addr = 16'h0010;
        cmd(2'd1, 16'd0);
        idle(6);
        #1;
        check("t2_ret", 32'(dut_ret), 32'd4);
        check("t2_pc", 32'(next_pc), 32'h10);
        check("t2_lock", 32'(lock), 32'd0);
        check("t2_cause", 32'(halt_cause), 32'd2);
        cmd(2'd1, 16'd0);
        idle(3);
        #1;
        check("t2_resume", 32'(dut_ret), 32'd7);
        check("t2_state", 32'(state), 32'd1);
        cmd(2'd3, 16'd0);
        bp_en = 1'b0;

        do_reset();
        cmd(2'd1, 16'd0);
        idle(2);
        cmd(2'd2, 16'd5);
        #1;
        check("t3_err", 32'(cmd_err), 32'd1);
        check("t3_state", 32'(state), 32'd1);
        idle(2);
        cmd(2'd3, 16'd0);
        idle(2);
        #1;
        check("t3_ret", 32'(dut_ret), 32'd6);
        check("t3_cause", 32'(halt_cause), 32'd0);

        do_reset();
        pc_mode = 1;
        cmd(2'd1, 16'd0);
        idle(12);
        #1;
        check("t4_ret", 32'(dut_ret), 32'd8);
        check("t4_cause", 32'(halt_cause), 32'd3);

        do_reset();
        pc_mode = 0;
        cmd(2'd2, 16'd100);
        idle(10);
        rst = 1'b1;
        #1;
        check("t5_lock", 32'(lock), 32'd0);
        check("t5_ret", 32'(dut_ret), 32'd10);
        tick();
        rst = 1'b0;
        #1;
        check("t5_state", 32'(state), 32'd0);
        check("t5_cnt", retired_cnt, 32'd0);

        pc_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_op = 2'($urandom_range(0, 3));
            step_count = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) begin
                bp_en = 1'($urandom_range(0, 1));
                bp_addr = 16'($urandom_range(0, 15) * 4);
            end
            tick();
        end
        cmd_valid = 1'b0;
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
